// File: rtl/sprite_pkg.sv
// ============================================================================
// Module  : sprite_pkg
// Purpose : Shared sprite ROM constants, requester ids and read-tag types.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sprite_pkg;

    localparam int ROM_ADDR_W   = 10;
    localparam int PAL_IDX_W    = 8;
    localparam int N_SPRITE_REQ = 4;

    typedef enum logic [1:0] {
        REQ_TANK0   = 2'd0,
        REQ_TANK1   = 2'd1,
        REQ_TURRET0 = 2'd2,
        REQ_BULLET  = 2'd3
    } req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_tag_t;

    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
// Module  : rr_picker
// Purpose : Combinational round-robin search starting at ptr.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_picker #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  winner,
    output logic             any
);

    int unsigned idx;

    always_comb begin
        gnt    = '0;
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = 32'(ptr) + 32'(k);
            if (idx >= 32'(N_REQ)) begin
                idx = idx - 32'(N_REQ);
            end
            if (!any && req[idx]) begin
                any      = 1'b1;
                winner   = ID_W'(idx);
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sprite_rom_arbiter.sv
// ============================================================================
// Module  : sprite_rom_arbiter
// Purpose : Round-robin share of one synchronous sprite ROM port, tagged returns.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int N_REQ   = N_SPRITE_REQ,
    parameter int ADDR_W  = ROM_ADDR_W,
    parameter int DATA_W  = PAL_IDX_W,
    parameter int ROM_LAT = 1
) (
    input  logic                    vga_clk,
    input  logic                    reset_n,
    input  logic                    frame_start,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]       rdata,
    output logic [ADDR_W-1:0]       rom_address,
    input  logic [DATA_W-1:0]       rom_q,
    output logic                    busy
);

    localparam int ID_W  = $clog2(N_REQ);
    // Stage 0 runs alongside the address register; the remaining ROM_LAT
    // stages track the ROM's own read latency.
    localparam int N_STG = ROM_LAT + 1;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0] rom_address_q, rom_address_d;
    tag_t              tag_q [N_STG];
    tag_t              tag_d [N_STG];

    logic [N_REQ-1:0]  pick_gnt;
    logic [ID_W-1:0]   pick_win;
    logic              pick_any;
    logic [ADDR_W-1:0] win_addr;

    rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .req    (req),
        .ptr    (ptr_q),
        .gnt    (pick_gnt),
        .winner (pick_win),
        .any    (pick_any)
    );

    always_comb begin
        win_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_win == ID_W'(i)) begin
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        ptr_d         = ptr_q;
        rom_address_d = rom_address_q;
        tag_d[0]      = '0;
        for (int s = 1; s < N_STG; s++) begin
            tag_d[s] = tag_q[s-1];
        end
        if (pick_any) begin
            rom_address_d  = win_addr;
            ptr_d          = ID_W'(wrap_inc(32'(pick_win), 32'(N_REQ)));
            tag_d[0].valid = 1'b1;
            tag_d[0].id    = pick_win;
        end
        // Frame realignment wins over the rotation update but not the transfer.
        if (frame_start) begin
            ptr_d = '0;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q         <= '0;
            rom_address_q <= '0;
            for (int s = 0; s < N_STG; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            ptr_q         <= ptr_d;
            rom_address_q <= rom_address_d;
            for (int s = 0; s < N_STG; s++) begin
                tag_q[s] <= tag_d[s];
            end
        end
    end

    always_comb begin
        rvalid = '0;
        if (reset_n && tag_q[N_STG-1].valid) begin
            rvalid[tag_q[N_STG-1].id] = 1'b1;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < N_STG; s++) begin
            busy = busy | tag_q[s].valid;
        end
    end

    assign gnt         = reset_n ? pick_gnt : '0;
    assign rdata       = rom_q;
    assign rom_address = rom_address_q;

endmodule

`default_nettype wire

// File: tb/tb_sprite_rom_arbiter.sv
// ============================================================================
// Module  : tb_sprite_rom_arbiter
// Purpose : Table, directed and random checks of sprite_rom_arbiter vs a queue model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sprite_rom_arbiter;
    import sprite_pkg::*;

    localparam int N_REQ   = 4;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 8;
    localparam int ROM_LAT = 1;

    logic                    vga_clk = 1'b0;
    logic                    reset_n = 1'b1;
    logic                    frame_start = 1'b0;
    logic [N_REQ-1:0]        req = '0;
    logic [N_REQ*ADDR_W-1:0] req_addr = '0;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]       rdata;
    logic [ADDR_W-1:0]       rom_address;
    logic [DATA_W-1:0]       rom_q;
    logic                    busy;

    sprite_rom_arbiter #(
        .N_REQ   (N_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .ROM_LAT (ROM_LAT)
    ) dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .req         (req),
        .req_addr    (req_addr),
        .gnt         (gnt),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .busy        (busy)
    );

    always #5 vga_clk = ~vga_clk;

    // ROM contents mem[a] = a[7:0], ROM_LAT cycles from registered address to q.
    logic [DATA_W-1:0] rom_pipe [ROM_LAT];
    always @(posedge vga_clk) begin
        rom_pipe[0] <= rom_address[7:0];
        for (int k = 1; k < ROM_LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
    end
    assign rom_q = rom_pipe[ROM_LAT-1];

    typedef struct {
        int             id;
        logic [7:0]     data;
        int             due;
    } ent_t;

    typedef struct {
        logic [3:0] req;
        logic       fs;
        logic [3:0] gnt;
        logic [3:0] rv;
    } vec_t;

    int               n_checks = 0;
    int               n_fail   = 0;
    int               cycle    = 0;
    int               m_ptr    = 0;
    logic [ADDR_W-1:0] m_last_addr = '0;
    ent_t             q[$];
    logic [ADDR_W-1:0] addr_v [N_REQ];
    logic [N_REQ-1:0] act_gnt, act_rv, m_eg;
    vec_t             tbl [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        #1;
        check("rst_gnt",    32'(gnt),         32'd0);
        check("rst_rvalid", 32'(rvalid),      32'd0);
        check("rst_busy",   32'(busy),        32'd0);
        check("rst_addr",   32'(rom_address), 32'd0);
        q.delete();
        m_ptr       = 0;
        m_last_addr = '0;
        @(posedge vga_clk);
        #1;
        cycle++;
        reset_n = 1'b1;
    endtask

    // One cycle: drive, check against the model, advance the model across the edge.
    task automatic step(input logic [N_REQ-1:0] r, input logic fs);
        int w;
        logic [N_REQ-1:0]  eg, erv;
        logic [DATA_W-1:0] ed;
        req         = r;
        frame_start = fs;
        for (int i = 0; i < N_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = addr_v[i];
        #1;
        w = -1;
        for (int k = 0; k < N_REQ; k++) begin
            if (w < 0 && r[(m_ptr + k) % N_REQ]) w = (m_ptr + k) % N_REQ;
        end
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        erv = '0;
        ed  = '0;
        if (q.size() > 0 && q[0].due == cycle) begin
            erv[q[0].id] = 1'b1;
            ed           = q[0].data;
        end
        act_gnt = gnt;
        act_rv  = rvalid;
        m_eg    = eg;
        check("gnt",        32'(gnt),         32'(eg));
        check("rvalid",     32'(rvalid),      32'(erv));
        check("rv_onehot",  32'($countones(rvalid) <= 1), 32'd1);
        if (erv != '0) check("rdata", 32'(rdata), 32'(ed));
        check("busy",       32'(busy),        32'(q.size() > 0));
        check("rom_addr",   32'(rom_address), 32'(m_last_addr));
        if (erv != '0) void'(q.pop_front());
        if (w >= 0) begin
            q.push_back('{id: w, data: addr_v[w][7:0], due: cycle + 1 + ROM_LAT});
            m_last_addr = addr_v[w];
            m_ptr       = (w + 1) % N_REQ;
        end
        if (fs) m_ptr = 0;
        @(posedge vga_clk);
        #1;
        cycle++;
    endtask

    logic [N_REQ-1:0] pend;
    int               waitc [N_REQ];

    task automatic random_phase(input int n_cyc, input bit use_fs);
        logic fs;
        for (int n = 0; n < n_cyc; n++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]   = 1'b1;
                    addr_v[i] = ADDR_W'($urandom_range(0, 1023));
                    waitc[i]  = 0;
                end
            end
            fs = use_fs && ($urandom_range(0, 15) == 0);
            step(pend, fs);
            for (int i = 0; i < N_REQ; i++) begin
                if (m_eg[i]) begin
                    if (!use_fs) check("fairness", 32'(waitc[i] < N_REQ), 32'd1);
                    pend[i] = 1'b0;
                end else if (pend[i]) begin
                    waitc[i]++;
                end
            end
        end
    endtask

    initial begin
        tbl[0]  = '{4'b0100, 1'b0, 4'b0100, 4'b0000};
        tbl[1]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000};
        tbl[2]  = '{4'b0000, 1'b1, 4'b0000, 4'b0100};
        tbl[3]  = '{4'b1111, 1'b0, 4'b0001, 4'b0000};
        tbl[4]  = '{4'b1111, 1'b0, 4'b0010, 4'b0000};
        tbl[5]  = '{4'b1111, 1'b0, 4'b0100, 4'b0001};
        tbl[6]  = '{4'b1111, 1'b0, 4'b1000, 4'b0010};
        tbl[7]  = '{4'b1111, 1'b0, 4'b0001, 4'b0100};
        tbl[8]  = '{4'b1111, 1'b0, 4'b0010, 4'b1000};
        tbl[9]  = '{4'b1111, 1'b0, 4'b0100, 4'b0001};
        tbl[10] = '{4'b1111, 1'b0, 4'b1000, 4'b0010};
        tbl[11] = '{4'b1010, 1'b1, 4'b0010, 4'b0100};
        tbl[12] = '{4'b1010, 1'b0, 4'b0010, 4'b1000};
        tbl[13] = '{4'b1010, 1'b0, 4'b1000, 4'b0010};
        tbl[14] = '{4'b0000, 1'b0, 4'b0000, 4'b0010};
        tbl[15] = '{4'b0000, 1'b0, 4'b0000, 4'b1000};
        tbl[16] = '{4'b0000, 1'b0, 4'b0000, 4'b0000};

        addr_v[REQ_TANK0]   = 10'h3A0;
        addr_v[REQ_TANK1]   = 10'h011;
        addr_v[REQ_TURRET0] = 10'h155;
        addr_v[REQ_BULLET]  = 10'h2FF;
        pend = '0;

        #2;
        apply_reset();

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].req, tbl[i].fs);
            check("tbl_gnt", 32'(act_gnt), 32'(tbl[i].gnt));
            check("tbl_rv",  32'(act_rv),  32'(tbl[i].rv));
        end

        // Reset one cycle after a grant: that read must never come back.
        apply_reset();
        step(4'b1111, 1'b0);
        check("pre_rst_gnt", 32'(act_gnt), 32'b0001);
        req = 4'b1111;
        apply_reset();
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b0);

        // Requester 0 drops after its grant while requester 3 keeps asking.
        step(4'b1001, 1'b0);
        check("drop_g0", 32'(act_gnt), 32'b0001);
        step(4'b1000, 1'b0);
        check("drop_g3", 32'(act_gnt), 32'b1000);
        step(4'b0000, 1'b0);
        check("drop_rv0", 32'(act_rv), 32'b0001);
        step(4'b0000, 1'b0);
        check("drop_rv3", 32'(act_rv), 32'b1000);

        random_phase(300, 1'b0);
        random_phase(300, 1'b1);
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
